itch_event_arbiter: RTL
=======================

Name: itch_event_arbiter

Overview:
- Round-robin arbiter and event queue behind the nine speculative ITCH decoders.
- Latches each decoder's one-cycle internal_valid pulse and its parsed type, then grants one source per cycle into a FIFO.
- Emits one serialized event per handshake (source id, parsed type, sequence number) to the downstream order-book stage.
- Owns decoder-output sharing: no pulse is lost unless the same source fires twice before being granted.

Parameters:
NUM_SRC, 9, decoder count; index 0..8 = add, cancel, delete, replace, exec, trade, add_mpid, broken, exec_price
TYPE_W, 4, parsed_type width per source
FIFO_DEPTH, 8, event queue entries; power of two, >=2
SEQ_W, 16, sequence-number width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
dec_valid  in  NUM_SRC  per-decoder internal_valid pulses; bit i = source i
dec_type  in  NUM_SRC*TYPE_W  per-decoder parsed_type; slice [i*TYPE_W +: TYPE_W] = source i
out_valid  out  1  event available
out_ready  in  1  downstream accepts; transfer when out_valid && out_ready
out_src  out  4  granted source index
out_type  out  TYPE_W  captured parsed_type
out_seq  out  SEQ_W  per-event sequence number
fifo_level  out  $clog2(FIFO_DEPTH+1)  current occupancy
overflow  out  1  sticky; set on any dropped pulse, cleared only by reset

Behaviour:
- Reset (rst low, async): pending[], type regs, rr_ptr, seq counter, FIFO pointers, out_valid, overflow, fifo_level all 0; out_src/out_type/out_seq 0.
- Pending capture, each source i:
  - dec_valid[i] && !pending[i]: pending[i]<=1, type_q[i]<=dec_type slice.
  - dec_valid[i] && pending[i] && not granted this cycle: drop; first-wins, so type_q kept; overflow<=1.
  - dec_valid[i] && granted this cycle: the new pulse is captured and pending stays 1.
  - Granted without new pulse: pending[i]<=0.
- Grant:
  - At most one per cycle.
  - Asserted when any pending and push allowed.
  - Push allowed when level<FIFO_DEPTH, or when level==FIFO_DEPTH and a pop occurs the same cycle.
  - Winner is the first pending index searching from rr_ptr upward, wrapping at NUM_SRC-1→0.
  - On grant, rr_ptr<=winner+1, wrapping to 0 after NUM_SRC-1.
- Push: entry {src, type_q[src], seq}; seq increments by 1 per push and wraps modulo 2^SEQ_W.
- FIFO full with no pop: no grant, pending retained, rr_ptr frozen.
- Output:
  - out_* driven from FIFO head register.
  - Stable while out_valid && !out_ready.
  - out_valid = (level!=0).
- Latency: dec_valid at edge N → pending at N+1 → grant/push at N+1 → out_valid at N+2 when FIFO empty and no competing pending. Nine simultaneous pulses → nine events on consecutive cycles given out_ready=1.
- Simultaneous push and pop: level unchanged, valid at every level including full.
- Reset mid-operation: queued events discarded; seq restarts at 0.

Optional Feature:
ITCH_ARB_DROP_CNT_EN:
- Defined: adds output port drop_cnt [15:0], incremented per dropped pulse and saturating at 16'hFFFF. Multiple sources dropping in one cycle add their popcount, also saturating.
- Undefined: port and counter absent; only the overflow flag is provided.

Decomposition:
- Package itch_arb_pkg holds:
  - localparams for the source indices (SRC_ADD=0 … SRC_EXEC_PRICE=8).
  - typedef struct packed itch_event_t {src[3:0], type[TYPE_W-1:0], seq[SEQ_W-1:0]}.
  - Default NUM_SRC value.
- One sub-module, itch_event_fifo: a synchronous FIFO of itch_event_t with registered head, level output, and same-cycle push/pop support when full.
- Round-robin selection stays in the top level as a function.

Test Plan:
- Single pulse: dec_valid=9'h001, type slice 4'h1, out_ready=1 → out_valid two cycles later with src=0, type=1, seq=0; level returns to 0.
- All nine pulse together: dec_valid=9'h1FF, out_ready=1 → nine consecutive events with src 0,1,…,8 and seq 0..8; no overflow.
- Round-robin fairness: after granting src 3, hold src 2 and src 5 pending → src 5 granted before src 2.
- Backpressure/full: out_ready=0, twelve distinct pulses across sources (DEPTH=8).
  - Required: level=8 and four stay pending.
  - Then out_ready=1 → all twelve delivered in order, seq contiguous.
- Collision drop: src 4 pulses type 4'h5, then again with 4'h9 while full.
  - Required: one event with type 5, overflow=1, drop_cnt=1 when ITCH_ARB_DROP_CNT_EN is defined.
- Async reset mid-stream: rst low with level=5 → out_valid=0 and level=0 immediately; next event after release carries seq=0.

Source files
------------

// File: rtl/itch_arb_pkg.sv
// Shared types and constants for the ITCH event arbiter: decoder source indices,
// default field widths and the serialized event record carried through the queue.
package itch_arb_pkg;

    localparam int ITCH_NUM_SRC = 9;
    localparam int ITCH_TYPE_W  = 4;
    localparam int ITCH_SEQ_W   = 16;
    localparam int ITCH_SRC_W   = 4;

    localparam logic [ITCH_SRC_W-1:0] SRC_ADD        = 4'd0;
    localparam logic [ITCH_SRC_W-1:0] SRC_CANCEL     = 4'd1;
    localparam logic [ITCH_SRC_W-1:0] SRC_DELETE     = 4'd2;
    localparam logic [ITCH_SRC_W-1:0] SRC_REPLACE    = 4'd3;
    localparam logic [ITCH_SRC_W-1:0] SRC_EXEC       = 4'd4;
    localparam logic [ITCH_SRC_W-1:0] SRC_TRADE      = 4'd5;
    localparam logic [ITCH_SRC_W-1:0] SRC_ADD_MPID   = 4'd6;
    localparam logic [ITCH_SRC_W-1:0] SRC_BROKEN     = 4'd7;
    localparam logic [ITCH_SRC_W-1:0] SRC_EXEC_PRICE = 4'd8;

    // "type" is a keyword, so the parsed-type field is called typ
    typedef struct packed {
        logic [ITCH_SRC_W-1:0]  src;
        logic [ITCH_TYPE_W-1:0] typ;
        logic [ITCH_SEQ_W-1:0]  seq;
    } itch_event_t;

endpackage

// File: rtl/itch_event_fifo.sv
// Event queue for the ITCH arbiter: oldest entry lives in a dedicated head register,
// younger entries in a ring buffer; push and pop may coincide at any level, including full.
module itch_event_fifo
    import itch_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  itch_event_t                       din,
    input  logic                              pop,
    output itch_event_t                       head,
    output logic                              valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    itch_event_t          mem_q [FIFO_DEPTH];
    itch_event_t          mem_d [FIFO_DEPTH];
    itch_event_t          head_q, head_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 do_push, do_pop;

    assign do_pop  = pop && (level_q != '0);
    assign do_push = push && ((level_q != LVL_W'(FIFO_DEPTH)) || do_pop);

    // The ring only ever holds level-1 entries, so a full queue never collides read and write slots
    always_comb begin
        mem_d    = mem_q;
        head_d   = head_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
            if (level_q == '0) begin
                head_d = din;
            end else begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
        end else if (do_pop && !do_push) begin
            level_d = level_q - 1'b1;
            if (level_q != LVL_W'(1)) begin
                head_d   = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end else if (do_push && do_pop) begin
            if (level_q == LVL_W'(1)) begin
                head_d = din;
            end else begin
                head_d          = mem_q[rd_ptr_q];
                rd_ptr_d        = rd_ptr_q + 1'b1;
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            head_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            head_q   <= head_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head  = head_q;
    assign valid = (level_q != '0);
    assign level = level_q;

endmodule

// File: rtl/itch_event_arbiter.sv
// Round-robin arbiter that latches the nine ITCH decoder pulses and serializes them into
// an event queue. Optional drop counter enabled by defining ITCH_ARB_DROP_CNT_EN.
module itch_event_arbiter
    import itch_arb_pkg::*;
#(
    parameter int NUM_SRC    = ITCH_NUM_SRC,
    parameter int TYPE_W     = ITCH_TYPE_W,
    parameter int FIFO_DEPTH = 8,
    parameter int SEQ_W      = ITCH_SEQ_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SRC-1:0]                dec_valid,
    input  logic [NUM_SRC*TYPE_W-1:0]         dec_type,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [3:0]                        out_src,
    output logic [TYPE_W-1:0]                 out_type,
    output logic [SEQ_W-1:0]                  out_seq,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overflow
`ifdef ITCH_ARB_DROP_CNT_EN
    ,
    output logic [15:0]                       drop_cnt
`endif
);

    localparam int SRC_W = ITCH_SRC_W;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic [NUM_SRC-1:0]  pending_q, pending_d;
    logic [TYPE_W-1:0]   type_q [NUM_SRC];
    logic [TYPE_W-1:0]   type_d [NUM_SRC];
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic                overflow_q, overflow_d;
    logic [NUM_SRC-1:0]  drop_vec;

    logic                win_found;
    logic [SRC_W-1:0]    win_idx;
    logic                fifo_pop, push_ok, grant;
    itch_event_t         ev_push, ev_head;
    logic                fifo_valid;
    logic [LVL_W-1:0]    level;

    // Scan downwards so the last hit written is the one closest to ptr going upward
    function automatic logic [SRC_W:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [SRC_W-1:0]   ptr);
        logic [SRC_W:0] res;
        int             idx;
        res = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (req[idx]) res = {1'b1, SRC_W'(idx)};
        end
        return res;
    endfunction

    assign {win_found, win_idx} = rr_pick(pending_q, rr_ptr_q);

    assign fifo_pop = fifo_valid && out_ready;
    assign push_ok  = (level != LVL_W'(FIFO_DEPTH)) || fifo_pop;
    assign grant    = win_found && push_ok;

    always_comb begin
        ev_push     = '0;
        ev_push.src = win_idx;
        ev_push.typ = type_q[win_idx];
        ev_push.seq = seq_q;
    end

    // A pulse landing on a source being granted this cycle refills it; otherwise first capture wins
    always_comb begin
        pending_d = pending_q;
        type_d    = type_q;
        drop_vec  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (dec_valid[i]) begin
                if (!pending_q[i] || (grant && (win_idx == SRC_W'(i)))) begin
                    pending_d[i] = 1'b1;
                    type_d[i]    = dec_type[i*TYPE_W +: TYPE_W];
                end else begin
                    drop_vec[i] = 1'b1;
                end
            end else if (grant && (win_idx == SRC_W'(i))) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        seq_d      = seq_q;
        overflow_d = overflow_q | (|drop_vec);
        if (grant) begin
            rr_ptr_d = (win_idx == SRC_W'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
            seq_d    = seq_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q  <= '0;
            type_q     <= '{default: '0};
            rr_ptr_q   <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            type_q     <= type_d;
            rr_ptr_q   <= rr_ptr_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef ITCH_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {12'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        drop_cnt_d = sat_add16(drop_cnt_q, 5'($countones(drop_vec)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    itch_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .din   (ev_push),
        .pop   (fifo_pop),
        .head  (ev_head),
        .valid (fifo_valid),
        .level (level)
    );

    assign out_valid  = fifo_valid;
    assign out_src    = ev_head.src;
    assign out_type   = ev_head.typ;
    assign out_seq    = ev_head.seq;
    assign fifo_level = level;
    assign overflow   = overflow_q;

endmodule
